move_input_ctrl: RTL and testbench

- Front-end stage directly upstream of the tictactoe core.
- Turns raw player buttons into the core's move inputs: a 3x3 cursor navigated by up/down/left/right, a one-hot sel_pos, and single-cycle buttonX/buttonO place pulses.
- Synchronizes and debounces every raw button.
- Drops illegal place requests and holds off until the core acknowledges the move.

---
 rtl/move_input_ctrl_pkg.sv | 35 +++
 rtl/move_input_ctrl_btn_debounce.sv | 48 ++++
 rtl/move_input_ctrl.sv | 139 +++++++++++++
 tb/tb_move_input_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_input_ctrl_pkg.sv
// Shared definitions for the move input front-end: FSM encoding, grid geometry
// and the cursor index to one-hot helper.
package move_input_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    localparam int ROWS         = 3;
    localparam int COLS         = 3;
    localparam int CURSOR_RESET = 4;

    localparam logic [1:0] RESET_ROW = 2'(CURSOR_RESET / COLS);
    localparam logic [1:0] RESET_COL = 2'(CURSOR_RESET % COLS);

    // Bit positions of the five buttons inside the conditioned press vector.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_PLACE = 4;
    localparam int NUM_BTN   = 5;

    function automatic logic [8:0] idx_to_onehot(input logic [3:0] idx);
        logic [8:0] oh;
        oh = '0;
        if (idx < 4'd9) begin
            oh = 9'b1 << idx;
        end
        return oh;
    endfunction

endpackage

// File: rtl/move_input_ctrl_btn_debounce.sv
// One raw button: two-flop synchronizer, consecutive-sample debouncer and a
// single-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic srst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (srst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != level_q) begin
                // The flip happens on the edge that sees the last required sample.
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    press_q <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Player input front-end for the tictactoe core: 3x3 cursor navigation and
// guarded single-cycle place pulses with acknowledge/timeout hand-off.
module move_input_ctrl
    import move_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic       turnX,
    input  logic       turnO,
    input  logic [8:0] occ_pos,
    output logic [8:0] sel_pos,
    output logic       buttonX,
    output logic       buttonO,
    output logic       reject,
    output logic       busy
);

    localparam int WCW = $clog2(ACK_TIMEOUT + 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_place, btn_right, btn_left, btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .srst_i (reset),
                .btn_i  (btn_raw[gi]),
                .press_o(press[gi])
            );
        end
    endgenerate

    state_e         state_q;
    logic [1:0]     row_q;
    logic [1:0]     col_q;
    logic [1:0]     row_d;
    logic [1:0]     col_d;
    logic [3:0]     cursor_d;
    logic [8:0]     sel_pos_q;
    logic           button_x_q;
    logic           button_o_q;
    logic           reject_q;
    logic           busy_q;
    logic [WCW-1:0] wait_cnt_q;
    logic           cursor_occ;
    logic           place_legal;

    // Highest-priority navigation event wins; the rest are dropped this cycle.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (press[BTN_UP]) begin
            row_d = (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;
        end else if (press[BTN_DOWN]) begin
            row_d = (row_q == 2'd0) ? 2'(ROWS - 1) : row_q - 2'd1;
        end else if (press[BTN_LEFT]) begin
            col_d = (col_q == 2'd0) ? 2'(COLS - 1) : col_q - 2'd1;
        end else if (press[BTN_RIGHT]) begin
            col_d = (col_q == 2'(COLS - 1)) ? 2'd0 : col_q + 2'd1;
        end
        cursor_d = {2'b00, row_d} * 4'(COLS) + {2'b00, col_d};
    end

    assign cursor_occ  = |(occ_pos & sel_pos_q);
    assign place_legal = (turnX ^ turnO) && !cursor_occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= RESET_ROW;
            col_q      <= RESET_COL;
            sel_pos_q  <= idx_to_onehot(4'(CURSOR_RESET));
            button_x_q <= 1'b0;
            button_o_q <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            button_x_q <= 1'b0;
            button_o_q <= 1'b0;
            reject_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press[BTN_PLACE]) begin
                        // Judged against the current cursor; coincident navigation is dropped.
                        if (place_legal) begin
                            button_x_q <= turnX;
                            button_o_q <= turnO;
                            busy_q     <= 1'b1;
                            state_q    <= ST_PULSE;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end else begin
                        row_q     <= row_d;
                        col_q     <= col_d;
                        sel_pos_q <= idx_to_onehot(cursor_d);
                    end
                end
                ST_PULSE: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (cursor_occ || (wait_cnt_q == WCW'(ACK_TIMEOUT - 1))) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel_pos = sel_pos_q;
    assign buttonX = button_x_q;
    assign buttonO = button_o_q;
    assign reject  = reject_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboard bench for move_input_ctrl: stimulus queues expected cursor moves,
// place pulses, rejects and busy windows; a monitor pops them as the DUT shows them.
module tb_move_input_ctrl;

    localparam int DEB = 4;
    localparam int ACK = 8;
    localparam int LAT = DEB + 3;

    localparam int K_SEL  = 0;
    localparam int K_X    = 1;
    localparam int K_O    = 2;
    localparam int K_REJ  = 3;
    localparam int K_BUSY = 4;

    localparam logic [4:0] M_UP    = 5'b00001;
    localparam logic [4:0] M_DOWN  = 5'b00010;
    localparam logic [4:0] M_LEFT  = 5'b00100;
    localparam logic [4:0] M_RIGHT = 5'b01000;
    localparam logic [4:0] M_PLACE = 5'b10000;

    typedef struct {
        string      name;
        int         kind;
        logic [8:0] sel;
        int         cyc;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;
    logic       turn_x = 1'b0;
    logic       turn_o = 1'b0;
    logic [8:0] occ = '0;
    logic [8:0] sel_pos;
    logic       button_x;
    logic       button_o;
    logic       reject;
    logic       busy;

    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    bit         mon_en = 1'b0;
    exp_t       sb_q[$];

    move_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .ACK_TIMEOUT    (ACK)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .btn_up   (btn[0]),
        .btn_down (btn[1]),
        .btn_left (btn[2]),
        .btn_right(btn[3]),
        .btn_place(btn[4]),
        .turnX    (turn_x),
        .turnO    (turn_o),
        .occ_pos  (occ),
        .sel_pos  (sel_pos),
        .buttonX  (button_x),
        .buttonO  (button_o),
        .reject   (reject),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string name, input int kind, input logic [8:0] sel,
                        input int c, input int len);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.sel  = sel;
        e.cyc  = c;
        e.len  = len;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, got, cyc);
        end
    endtask

    // Monitor side: one popped entry per observed DUT event.
    task automatic observe(input int kind, input logic [8:0] sel, input int len);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected: got kind=%0d sel=%b len=%0d at cycle %0d, expected nothing",
                     kind, sel, len, cyc);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.sel !== sel || e.cyc != cyc ||
                (kind == K_BUSY && e.len != len)) begin
                n_miss++;
                $display("FAIL %s: got kind=%0d sel=%b cyc=%0d len=%0d, expected kind=%0d sel=%b cyc=%0d len=%0d",
                         e.name, kind, sel, cyc, len, e.kind, e.sel, e.cyc, e.len);
            end else begin
                $display("ok   %s: kind=%0d sel=%b cyc=%0d", e.name, kind, sel, cyc);
            end
        end
    endtask

    logic [8:0] prev_sel  = 9'b000010000;
    logic       prev_busy = 1'b0;
    logic       prev_x    = 1'b0;
    logic       prev_o    = 1'b0;
    int         busy_run  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                prev_sel  = 9'b000010000;
                prev_busy = 1'b0;
                prev_x    = 1'b0;
                prev_o    = 1'b0;
                busy_run  = 0;
            end else begin
                n_vec++;
                if (!$onehot(sel_pos) || (button_x && button_o) ||
                    (button_x && prev_x) || (button_o && prev_o)) begin
                    n_miss++;
                    $display("FAIL invariant: sel=%b X=%b O=%b prevX=%b prevO=%b at cycle %0d, required one-hot sel and single non-overlapping pulses",
                             sel_pos, button_x, button_o, prev_x, prev_o, cyc);
                end
                if (sel_pos !== prev_sel) observe(K_SEL, sel_pos, 0);
                if (button_x) observe(K_X, sel_pos, 0);
                if (button_o) observe(K_O, sel_pos, 0);
                if (reject) observe(K_REJ, sel_pos, 0);
                if (busy) begin
                    busy_run++;
                end else if (prev_busy) begin
                    observe(K_BUSY, sel_pos, busy_run);
                    busy_run = 0;
                end
                prev_sel  = sel_pos;
                prev_busy = busy;
                prev_x    = button_x;
                prev_o    = button_o;
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_press(input logic [4:0] mask, output int c);
        @(posedge clk);
        #1;
        c   = cyc;
        btn = btn | mask;
    endtask

    task automatic finish_press(input logic [4:0] mask, input int c);
        wait_until(c + 8);
        btn = btn & ~mask;
        wait_until(c + 22);
    endtask

    task automatic nav(input string name, input logic [4:0] mask, input logic [8:0] exp_sel);
        int c;
        start_press(mask, c);
        push(name, K_SEL, exp_sel, c + LAT, 0);
        finish_press(mask, c);
    endtask

    task automatic place_reject(input string name, input logic [8:0] cur_sel);
        int c;
        start_press(M_PLACE, c);
        push(name, K_REJ, cur_sel, c + LAT, 0);
        finish_press(M_PLACE, c);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_sel", 32'(sel_pos), 32'h010);
        chk("reset_x", 32'(button_x), 32'h0);
        chk("reset_o", 32'(button_o), 32'h0);
        chk("reset_rej", 32'(reject), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        mon_en = 1'b1;

        // Navigation walk with wrap, then coincident-press priority
        nav("nav_right_4to5", M_RIGHT, 9'b000100000);
        nav("nav_up_5to8", M_UP, 9'b100000000);
        nav("nav_up_8to2", M_UP, 9'b000000100);
        nav("nav_left_2to1", M_LEFT, 9'b000000010);
        nav("nav_down_1to7", M_DOWN, 9'b010000000);
        nav("nav_up_over_right_7to1", M_UP | M_RIGHT, 9'b000000010);
        nav("nav_down_over_left_1to7", M_DOWN | M_LEFT, 9'b010000000);

        // Legal X place at centre, acknowledged by the core
        do_reset(2);
        turn_x = 1'b1;
        turn_o = 1'b0;
        occ    = '0;
        start_press(M_PLACE, c);
        push("place_x_pulse", K_X, 9'b000010000, c + LAT, 0);
        push("place_x_ack_busy", K_BUSY, 9'b000010000, c + LAT + 2, 2);
        wait_until(c + 8);
        occ = 9'b000010000;
        finish_press(M_PLACE, c);

        // Illegal places
        turn_x = 1'b0;
        turn_o = 1'b1;
        place_reject("reject_occupied", 9'b000010000);
        occ    = '0;
        turn_o = 1'b0;
        place_reject("reject_no_turn", 9'b000010000);
        turn_x = 1'b1;
        turn_o = 1'b1;
        place_reject("reject_both_turns", 9'b000010000);

        // Bouncing place button must never debounce
        turn_o = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            btn[4] = ~btn[4];
        end
        btn[4] = 1'b0;
        wait_until(cyc + 15);

        // Timeout with a navigation press landing inside the busy window
        turn_x = 1'b0;
        turn_o = 1'b1;
        start_press(M_PLACE, c);
        push("place_o_pulse", K_O, 9'b000010000, c + LAT, 0);
        push("place_o_timeout_busy", K_BUSY, 9'b000010000, c + LAT + 1 + ACK, 1 + ACK);
        wait_until(c + 2);
        btn = btn | M_UP;
        wait_until(c + 8);
        btn = btn & ~M_PLACE;
        wait_until(c + 10);
        btn = btn & ~M_UP;
        wait_until(c + 30);
        nav("nav_after_timeout_4to5", M_RIGHT, 9'b000100000);

        // Reset while waiting for the acknowledge
        turn_x = 1'b1;
        turn_o = 1'b0;
        start_press(M_PLACE, c);
        push("place_x_before_reset", K_X, 9'b000100000, c + LAT, 0);
        wait_until(c + 8);
        btn = btn & ~M_PLACE;
        wait_until(c + 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_sel", 32'(sel_pos), 32'h010);
        chk("midreset_busy", 32'(busy), 32'h0);
        chk("midreset_x", 32'(button_x), 32'h0);
        wait_until(cyc + 25);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
